// File: rtl/adder_bist_checker_if.sv
// -----------------------------------------------------------------------------
// adder_bist_checker_if
// Purpose : bundles the adder self-test controller's stimulus/response bus and
//           its control/status signals so the checker and its environment
//           connect through a single port.
// Signals : start            - begin a sweep (environment -> checker)
//           dut_a/dut_b      - operands applied to the adder under test
//           dut_cin          - carry-in applied to the adder under test
//           dut_sum/dut_cout - response of the adder under test
//           busy/done/pass   - sweep status
//           err_count        - saturating mismatch count
//           first_fail_vec   - {a,b,cin} of the first mismatching vector
//           first_fail_valid - first_fail_vec holds a captured vector
// Modports: master = checker side, slave = adder/environment side.
// -----------------------------------------------------------------------------
interface adder_bist_checker_if #(
   parameter int WIDTH = 1,
   parameter int ERR_W = 8
);
   logic               start;
   logic [WIDTH-1:0]   dut_a;
   logic [WIDTH-1:0]   dut_b;
   logic               dut_cin;
   logic [WIDTH-1:0]   dut_sum;
   logic               dut_cout;
   logic               busy;
   logic               done;
   logic               pass;
   logic [ERR_W-1:0]   err_count;
   logic [2*WIDTH:0]   first_fail_vec;
   logic               first_fail_valid;

   modport master (
      input  start, dut_sum, dut_cout,
      output dut_a, dut_b, dut_cin, busy, done, pass,
             err_count, first_fail_vec, first_fail_valid
   );

   modport slave (
      output start, dut_sum, dut_cout,
      input  dut_a, dut_b, dut_cin, busy, done, pass,
             err_count, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/adder_bist_checker.sv
// -----------------------------------------------------------------------------
// adder_bist_checker
// Purpose : synthesizable self-test for a WIDTH-bit adder. Sweeps every
//           {a,b,cin} combination in ascending order, waits SETTLE cycles per
//           vector, compares the adder response with a + b + cin and records a
//           saturating error count plus the first failing vector.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset (everything to zero, IDLE)
//           bus   - adder_bist_checker_if.master (stimulus, response, status)
// -----------------------------------------------------------------------------
module adder_bist_checker #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   adder_bist_checker_if.master  bus
);

   localparam int               VW       = 2 * WIDTH + 1;
   localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
   localparam logic [VW-1:0]    VEC_LAST = {VW{1'b1}};
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_APPLY = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [VW-1:0]      vec_q, vec_d;
   logic [3:0]         settle_q, settle_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [VW-1:0]      ffv_q, ffv_d;
   logic               ffvalid_q, ffvalid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [WIDTH:0]     exp_res;
   logic               mismatch;

   // Reference result {cout, sum} for a vector laid out as {a, b, cin}.
   function automatic logic [WIDTH:0] golden_sum(input logic [VW-1:0] v);
      return {1'b0, v[VW-1 -: WIDTH]} + {1'b0, v[WIDTH:1]} + {{WIDTH{1'b0}}, v[0]};
   endfunction

   // Compare uses the registered vector, so the value on the adder inputs is
   // exactly the one being judged.
   assign exp_res  = golden_sum(vec_q);
   assign mismatch = (bus.dut_sum != exp_res[WIDTH-1:0]) || (bus.dut_cout != exp_res[WIDTH]);

   // Next-state and result-update logic for the sweep sequencer.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      settle_d  = settle_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d   = S_APPLY;
               vec_d     = '0;
               err_d     = '0;
               ffv_d     = '0;
               ffvalid_d = 1'b0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
            end else begin
               state_d   = state_q;
            end
         end
         S_APPLY: begin
            settle_d = SETTLE_L;
            if (SETTLE_L == 4'd0) begin
               state_d = S_CHECK;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Counter was loaded with SETTLE; leaving at 1 gives SETTLE WAIT cycles.
            if (settle_q <= 4'd1) begin
               settle_d = 4'd0;
               state_d  = S_CHECK;
            end else begin
               settle_d = settle_q - 4'd1;
               state_d  = S_WAIT;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + ERR_W'(1);
               end else begin
                  err_d = err_q;
               end
               if (!ffvalid_q) begin
                  ffv_d     = vec_q;
                  ffvalid_d = 1'b1;
               end else begin
                  ffv_d     = ffv_q;
                  ffvalid_d = ffvalid_q;
               end
            end else begin
               err_d = err_q;
            end
            if (vec_q == VEC_LAST) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               // Includes a mismatch on the final vector.
               pass_d  = (err_d == '0);
            end else begin
               vec_d   = vec_q + VW'(1);
               state_d = S_APPLY;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   // State and result registers; asynchronous reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         vec_q     <= '0;
         settle_q  <= 4'd0;
         err_q     <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         settle_q  <= settle_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
      end
   end

   assign bus.dut_a            = vec_q[VW-1 -: WIDTH];
   assign bus.dut_b            = vec_q[WIDTH:1];
   assign bus.dut_cin          = vec_q[0];
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_bist_checker
// Two checker instances: A (WIDTH=1, SETTLE=1, ERR_W=8) and B (WIDTH=2,
// SETTLE=0, ERR_W=2), each driving a behavioural adder with selectable faults.
// Expected results come from an arithmetic sweep over all vectors.
// -----------------------------------------------------------------------------
module tb_adder_bist_checker;

   localparam int W_A = 1, S_A = 1, E_A = 8;
   localparam int W_B = 2, S_B = 0, E_B = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   int          n_pass  = 0;
   int          n_total = 0;
   int          mode_a  = 0;
   int          mode_b  = 0;
   logic [7:0]  mask_a  = 8'h00;
   logic [31:0] mask_b  = 32'h0;

   adder_bist_checker_if #(.WIDTH(W_A), .ERR_W(E_A)) ifa ();
   adder_bist_checker_if #(.WIDTH(W_B), .ERR_W(E_B)) ifb ();

   adder_bist_checker #(.WIDTH(W_A), .SETTLE(S_A), .ERR_W(E_A)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.master)
   );

   adder_bist_checker #(.WIDTH(W_B), .SETTLE(S_B), .ERR_W(E_B)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.master)
   );

   always #5 clk = ~clk;

   // Behavioural adder response {cout,sum}: 0 golden, 1 cout stuck 0,
   // 2 sum inverted, 3 cout inverted where flip is set.
   function automatic int dut_resp(int w, int mode, int v, bit flip);
      int a, b, c, r;
      a = v >> (w + 1);
      b = (v >> 1) & ((1 << w) - 1);
      c = v & 1;
      r = a + b + c;
      case (mode)
         1: r = r & ((1 << w) - 1);
         2: r = r ^ ((1 << w) - 1);
         3: if (flip) r = r ^ (1 << w);
         default: ;
      endcase
      return r;
   endfunction

   logic [2:0] va;
   logic [4:0] vb;
   int         resp_a, resp_b;

   always_comb begin
      va            = {ifa.dut_a, ifa.dut_b, ifa.dut_cin};
      resp_a        = dut_resp(W_A, mode_a, int'(va), mask_a[va]);
      ifa.dut_sum   = resp_a[0];
      ifa.dut_cout  = resp_a[1];
   end

   always_comb begin
      vb            = {ifb.dut_a, ifb.dut_b, ifb.dut_cin};
      resp_b        = dut_resp(W_B, mode_b, int'(vb), mask_b[vb]);
      ifb.dut_sum   = resp_b[1:0];
      ifb.dut_cout  = resp_b[2];
   end

   function automatic int g_w(int i);     return (i == 0) ? W_A : W_B; endfunction
   function automatic int g_slot(int i);  return ((i == 0) ? S_A : S_B) + 2; endfunction
   function automatic int g_emax(int i);  return (i == 0) ? (1 << E_A) - 1 : (1 << E_B) - 1; endfunction
   function automatic int g_vec(int i);
      return (i == 0) ? int'({ifa.dut_a, ifa.dut_b, ifa.dut_cin}) : int'({ifb.dut_a, ifb.dut_b, ifb.dut_cin});
   endfunction
   function automatic int g_err(int i);   return (i == 0) ? int'(ifa.err_count) : int'(ifb.err_count); endfunction
   function automatic int g_ff(int i);    return (i == 0) ? int'(ifa.first_fail_vec) : int'(ifb.first_fail_vec); endfunction
   function automatic logic g_valid(int i); return (i == 0) ? ifa.first_fail_valid : ifb.first_fail_valid; endfunction
   function automatic logic g_busy(int i);  return (i == 0) ? ifa.busy : ifb.busy; endfunction
   function automatic logic g_done(int i);  return (i == 0) ? ifa.done : ifb.done; endfunction
   function automatic logic g_pass(int i);  return (i == 0) ? ifa.pass : ifb.pass; endfunction

   task automatic set_start(input int i, input logic v);
      if (i == 0) ifa.start = v;
      else        ifb.start = v;
   endtask

   // Reference: count vectors whose response differs from a+b+cin.
   task automatic ref_model(input int i, input int mode, output int e_err, output int e_ff, output bit e_valid);
      int w, cnt;
      w = g_w(i);
      cnt = 0; e_ff = 0; e_valid = 1'b0;
      for (int v = 0; v < (1 << (2 * w + 1)); v++) begin
         int a, b, c;
         bit flip;
         a = v >> (w + 1);
         b = (v >> 1) & ((1 << w) - 1);
         c = v & 1;
         flip = (i == 0) ? mask_a[v] : mask_b[v];
         if (dut_resp(w, mode, v, flip) != a + b + c) begin
            cnt++;
            if (!e_valid) begin e_valid = 1'b1; e_ff = v; end
         end
      end
      e_err = (cnt > g_emax(i)) ? g_emax(i) : cnt;
   endtask

   task automatic all_zero(input int i, input string tag);
      n_total++;
      if ({g_busy(i), g_done(i), g_pass(i), g_valid(i)} !== 4'b0000 || g_err(i) != 0 || g_ff(i) != 0 || g_vec(i) != 0) begin
         $display("FAIL %s: busy=%0b done=%0b pass=%0b valid=%0b err=%0d ff=%0d vec=%0d, required all 0",
                  tag, g_busy(i), g_done(i), g_pass(i), g_valid(i), g_err(i), g_ff(i), g_vec(i));
      end else n_pass++;
   endtask

   // One full sweep; optional re-pulse of start at edge count repulse_at.
   task automatic run_sweep(input int i, input int mode, input int repulse_at, input string tag);
      int e_err, e_ff, n, cnt, last, v, budget, bad;
      bit e_valid;
      int seq[$];
      if (i == 0) mode_a = mode; else mode_b = mode;
      ref_model(i, mode, e_err, e_ff, e_valid);
      n = 1 << (2 * g_w(i) + 1);
      budget = n * g_slot(i) + 20;
      @(negedge clk);
      set_start(i, 1'b1);
      @(posedge clk);
      #1;
      set_start(i, 1'b0);
      n_total++;
      if (g_busy(i) !== 1'b1) $display("FAIL %s busy_after_start: got %0b want 1", tag, g_busy(i));
      else n_pass++;
      n_total++;
      if ({g_done(i), g_pass(i), g_valid(i)} !== 3'b000 || g_err(i) != 0) begin
         $display("FAIL %s cleared_at_start: done=%0b pass=%0b valid=%0b err=%0d want 0", tag, g_done(i), g_pass(i), g_valid(i), g_err(i));
      end else n_pass++;
      last = g_vec(i);
      seq.push_back(last);
      cnt = 0;
      while (g_done(i) !== 1'b1 && cnt < budget) begin
         @(posedge clk);
         cnt++;
         #1;
         set_start(i, (cnt == repulse_at) ? 1'b1 : 1'b0);
         v = g_vec(i);
         if (v != last) seq.push_back(v);
         last = v;
      end
      set_start(i, 1'b0);
      n_total++;
      if (cnt != n * g_slot(i)) $display("FAIL %s done_latency: got %0d edges want %0d", tag, cnt, n * g_slot(i));
      else n_pass++;
      n_total++;
      if (g_err(i) != e_err) $display("FAIL %s err_count: got %0d want %0d", tag, g_err(i), e_err);
      else n_pass++;
      n_total++;
      if (g_valid(i) !== e_valid || g_ff(i) != e_ff) begin
         $display("FAIL %s first_fail: got valid=%0b vec=%0d want valid=%0b vec=%0d", tag, g_valid(i), g_ff(i), e_valid, e_ff);
      end else n_pass++;
      n_total++;
      if (g_pass(i) !== (e_err == 0) || g_busy(i) !== 1'b0) begin
         $display("FAIL %s pass_busy: got pass=%0b busy=%0b want pass=%0b busy=0", tag, g_pass(i), g_busy(i), e_err == 0);
      end else n_pass++;
      bad = (seq.size() != n) ? 1 : 0;
      foreach (seq[k]) if (seq[k] != k) bad++;
      n_total++;
      if (bad != 0) $display("FAIL %s vec_sequence: got %0d steps with %0d errors want %0d ascending", tag, seq.size(), bad, n);
      else n_pass++;
   endtask

   task automatic test_reset();
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      all_zero(0, "reset_a");
      all_zero(1, "reset_b");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_faults();
      run_sweep(0, 0, 0, "golden_a");
      run_sweep(0, 1, 0, "cout_stuck_a");
      run_sweep(0, 2, 0, "sum_inv_a");
      run_sweep(1, 0, 0, "golden_b");
      run_sweep(1, 2, 0, "saturate_b");
   endtask

   task automatic test_back_to_back();
      run_sweep(0, 1, 7, "busy_restart_1");
      run_sweep(0, 1, 0, "done_restart_2");
      run_sweep(1, 2, 20, "busy_restart_b");
   endtask

   task automatic test_reset_mid();
      int cnt;
      mode_a = 0;
      @(negedge clk);
      ifa.start = 1'b1;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      cnt = 0;
      while (g_vec(0) != 5 && cnt < 40) begin
         @(posedge clk);
         cnt++;
         #1;
      end
      n_total++;
      if (g_vec(0) != 5) $display("FAIL reach_vec5: got %0d want 5", g_vec(0));
      else n_pass++;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      all_zero(0, "reset_mid_a");
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(0, 0, 0, "after_reset_a");
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         mask_a = 8'($urandom);
         run_sweep(0, 3, int'($urandom_range(1, 20)), "random_a");
         mask_b = $urandom;
         run_sweep(1, 3, int'($urandom_range(1, 60)), "random_b");
      end
   endtask

   initial begin
      test_reset();
      test_faults();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/adder_bist_checker.md
Name: adder_bist_checker

Overview:
- Hardware self-test controller for a WIDTH-bit adder. It sweeps every input combination of {a, b, cin} into the device under test (DUT) in ascending order, samples the DUT's sum and carry-out, and compares them against an internally computed golden result.
- It records an error count and the first failing vector. It replaces bench-only stimulus with a synthesizable stimulus-plus-checker, so full-adder and ripple-adder instances can be self-tested on silicon or FPGA.

Parameters:
- WIDTH, 1, operand width of the DUT adder (1 = single full adder).
- SETTLE, 1, idle cycles between applying a vector and sampling the DUT (0..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- dut_a  output  WIDTH  DUT operand a.
- dut_b  output  WIDTH  DUT operand b.
- dut_cin  output  1  DUT carry-in.
- dut_sum  input  WIDTH  DUT sum result.
- dut_cout  input  1  DUT carry-out.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next start.
- pass  output  1  valid while done=1; 1 when err_count==0.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- first_fail_vec  output  2*WIDTH+1  {a,b,cin} of the first mismatch.
- first_fail_valid  output  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: dut_a, dut_b, dut_cin, busy, done, pass, err_count, first_fail_vec, first_fail_valid.
- Vector register vec, 2*WIDTH+1 bits, layout {a, b, cin}: cin is the LSB and a occupies the MSBs. N = 2^(2*WIDTH+1) vectors.
- dut_a, dut_b and dut_cin are driven directly from the vec register fields. They are glitch-free and stable for the whole vector slot.
- Expected result: {exp_cout, exp_sum} = a + b + cin, computed at WIDTH+1 bits. A mismatch is (dut_sum != exp_sum) OR (dut_cout != exp_cout).
- State machine states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE, start=1: next state APPLY. Clear vec, err_count, first_fail_vec and first_fail_valid. Set busy=1.
- APPLY: one cycle. Next state is WAIT, or CHECK directly if SETTLE=0. A settle counter is loaded with SETTLE.
- WAIT: stay for exactly SETTLE cycles, then go to CHECK.
- CHECK: one cycle; sample the DUT outputs and compare.
  - On mismatch, increment err_count, saturating at 2^ERR_W-1.
  - On mismatch with first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec is all-ones, next state is DONE. Otherwise vec increments and the next state is APPLY.
- Slot length: each vector occupies SETTLE+2 cycles.
- Latency: done rises exactly N*(SETTLE+2) rising edges after the edge that sampled start.
- DONE: busy=0, done=1, pass=(err_count==0). Results and the last vec on the dut_* outputs are held.
  - start=1 in DONE clears the results, drops done and pass, and enters APPLY with vec=0, exactly as from IDLE.
- start while busy=1 is ignored and has no effect on the sweep.
- Compare and capture: the comparison uses the registered vec, never the incremented value. Error increment and first-fail capture in the same CHECK cycle both take effect.
- Saturation: once err_count reaches its maximum it holds; the sweep continues to completion.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No partial results are retained.

Test Plan:
- Golden full adder, WIDTH=1, SETTLE=1, start pulse -> busy for 24 cycles; done rises 24 edges after start; pass=1, err_count=0, first_fail_valid=0; dut_{a,b,cin} step through 000..111.
- DUT with dut_cout stuck at 0 (WIDTH=1) -> err_count=4 (vectors 011, 101, 110, 111); first_fail_vec=3'b011, first_fail_valid=1, pass=0.
- DUT with dut_sum inverted (WIDTH=1, SETTLE=0) -> 8 errors; done 16 edges after start; first_fail_vec=3'b000.
- WIDTH=2, ERR_W=2, sum inverted (32 vectors) -> err_count saturates at 3; the sweep still completes; done rises after 96 edges with SETTLE=1; first_fail_vec=5'b00000.
- rst_n pulled low during vector 5 -> all outputs 0 asynchronously. A following start runs a full clean sweep with pass=1 on a golden DUT.
- start re-pulsed while busy -> ignored and the sweep timing is unchanged. start in DONE -> done and err_count clear next cycle; a second identical sweep reproduces the same results.
